// File: rtl/program_loader_if.sv
// Host/core bus of the program loader: load request, word stream, instruction-memory write port
// and PC override/run controls. The loader is the slave; the boot host side is the master.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [31:0]       start_pc;
    logic [31:0]       exp_sum;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] instructionInput;
    logic              instructionWriteEnable;
    logic [ADDR_W-1:0] writeAddr;
    logic [31:0]       PC;
    logic              PC_set;
    logic              core_run;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  load_start, load_len, start_pc, exp_sum, in_valid, in_data,
        output in_ready, instructionInput, instructionWriteEnable, writeAddr,
               PC, PC_set, core_run, busy, done, err
    );

    modport master (
        output load_start, load_len, start_pc, exp_sum, in_valid, in_data,
        input  in_ready, instructionInput, instructionWriteEnable, writeAddr,
               PC, PC_set, core_run, busy, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Boot sequencer: streams host words into instruction memory, pulses PC_set, then releases the core.
// Define LOADER_CHECKSUM_EN to verify a 32-bit wrapping sum of the loaded words before release.
module program_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StSetpc, StRun} state_e;

    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   len_q;
    logic [31:0]       pc_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       pc_out_q;
    logic              pc_set_q;
    logic              core_run_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              start_req;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] exp_q;
    logic [31:0] sum_q;
    logic        chk_phase_q;
    logic        match_q;
`else
    logic unused_exp_sum;
    assign unused_exp_sum = ^bus.exp_sum;
`endif

    // A start request is honoured only from IDLE or RUN; LOAD and SETPC ignore it.
    assign start_req = bus.load_start && (state_q == StIdle || state_q == StRun);
    assign last_word = (cnt_q == len_q - CntOne);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            pc_q        <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pc_out_q    <= '0;
            pc_set_q    <= 1'b0;
            core_run_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            exp_q       <= '0;
            sum_q       <= '0;
            chk_phase_q <= 1'b0;
            match_q     <= 1'b0;
`endif
        end else begin
            we_q     <= 1'b0;
            pc_set_q <= 1'b0;
            done_q   <= 1'b0;

            if (start_req) begin
                len_q      <= bus.load_len;
                pc_q       <= bus.start_pc;
                cnt_q      <= '0;
                core_run_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                exp_q      <= bus.exp_sum;
                sum_q      <= '0;
`endif
                if (bus.load_len > MaxLen) begin
                    err_q      <= 1'b1;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= StIdle;
                end else if (bus.load_len == '0) begin
                    err_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    // Empty image: the sum is 0, so the compare resolves right here.
                    match_q     <= (bus.exp_sum == 32'd0);
                    chk_phase_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= StSetpc;
`else
                    pc_out_q <= bus.start_pc;
                    pc_set_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StRun;
`endif
                end else begin
                    err_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= StLoad;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StLoad: begin
                        if (bus.in_valid && in_ready_q) begin
                            we_q    <= 1'b1;
                            waddr_q <= cnt_q[ADDR_W-1:0];
                            wdata_q <= bus.in_data;
                            cnt_q   <= cnt_q + CntOne;
`ifdef LOADER_CHECKSUM_EN
                            sum_q   <= sum_q + 32'(bus.in_data);
`endif
                            if (last_word) begin
                                in_ready_q <= 1'b0;
                                state_q    <= StSetpc;
`ifdef LOADER_CHECKSUM_EN
                                chk_phase_q <= 1'b0;
`endif
                            end
                        end
                    end
                    StSetpc: begin
`ifdef LOADER_CHECKSUM_EN
                        if (!chk_phase_q) begin
                            match_q     <= (sum_q == exp_q);
                            chk_phase_q <= 1'b1;
                        end else if (match_q) begin
                            pc_out_q <= pc_q;
                            pc_set_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= StRun;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
`else
                        pc_out_q <= pc_q;
                        pc_set_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StRun;
`endif
                    end
                    StRun: begin
                        // First RUN cycle follows the PC_set pulse; release the core here.
                        if (!core_run_q) begin
                            core_run_q <= 1'b1;
                            done_q     <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.in_ready               = in_ready_q;
    assign bus.instructionInput       = wdata_q;
    assign bus.instructionWriteEnable = we_q;
    assign bus.writeAddr              = waddr_q;
    assign bus.PC                     = pc_out_q;
    assign bus.PC_set                 = pc_set_q;
    assign bus.core_run               = core_run_q;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.err                    = err_q;
endmodule
